// File: rtl/pipe_stall_flush_ctrl.sv
// rtl/pipe_stall_flush_ctrl.sv - PC, IF/ID and ID/EX registers with stall/flush/squash control
// Also keeps saturating stall/squash counters and a sticky stall watchdog.
module pipe_stall_flush_ctrl #(
    parameter int WL       = 32,
    parameter int WLinput  = 5,
    parameter int CTRLW    = 8,
    parameter int CNTW     = 16,
    parameter int MAXSTALL = 8
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               PCSrcD,
    input  logic [WL-1:0]      PCBranchD,
    input  logic [WL-1:0]      InstrF,
    output logic [WL-1:0]      PCF,
    output logic [WL-1:0]      InstrD,
    output logic [WL-1:0]      PCPlus4D,
    output logic               ValidD,
    input  logic [CTRLW-1:0]   CtrlD,
    input  logic [WL-1:0]      RFRD1D,
    input  logic [WL-1:0]      RFRD2D,
    input  logic [WL-1:0]      SImmD,
    input  logic [WLinput-1:0] rsD,
    input  logic [WLinput-1:0] rtD,
    input  logic [WLinput-1:0] rtdD,
    output logic [CTRLW-1:0]   CtrlE,
    output logic [WL-1:0]      RFRD1E,
    output logic [WL-1:0]      RFRD2E,
    output logic [WL-1:0]      SImmE,
    output logic [WLinput-1:0] rsE,
    output logic [WLinput-1:0] rtE,
    output logic [WLinput-1:0] rtdE,
    output logic               ValidE,
    output logic [CNTW-1:0]    StallCnt,
    output logic [CNTW-1:0]    SquashCnt,
    output logic               StallErr
);

    localparam int RUNW = $clog2(MAXSTALL + 2);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [RUNW-1:0] RUN_TRIP = RUNW'(MAXSTALL);
    localparam logic [RUNW-1:0] RUN_CAP  = RUNW'(MAXSTALL + 1);

    logic [RUNW-1:0] runs;
    logic [WL-1:0]   pc_plus4;
    logic            squash;

    assign pc_plus4 = PCF + WL'(4);
    // A stalled branch is not yet resolved, so stall masks the squash.
    assign squash   = PCSrcD & ~Stall;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            PCF <= '0;
        end else if (!Stall) begin
            PCF <= PCSrcD ? PCBranchD : pc_plus4;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (squash) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!Stall) begin
            InstrD   <= InstrF;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            CtrlE  <= '0;
            RFRD1E <= '0;
            RFRD2E <= '0;
            SImmE  <= '0;
            rsE    <= '0;
            rtE    <= '0;
            rtdE   <= '0;
            ValidE <= 1'b0;
        end else if (Flush) begin
            CtrlE  <= '0;
            RFRD1E <= '0;
            RFRD2E <= '0;
            SImmE  <= '0;
            rsE    <= '0;
            rtE    <= '0;
            rtdE   <= '0;
            ValidE <= 1'b0;
        end else begin
            CtrlE  <= CtrlD;
            RFRD1E <= RFRD1D;
            RFRD2E <= RFRD2D;
            SImmE  <= SImmD;
            rsE    <= rsD;
            rtE    <= rtD;
            rtdE   <= rtdD;
            ValidE <= ValidD;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            StallCnt  <= '0;
            SquashCnt <= '0;
        end else begin
            if (Stall && StallCnt != CNT_MAX) begin
                StallCnt <= StallCnt + CNTW'(1);
            end
            if (squash && SquashCnt != CNT_MAX) begin
                SquashCnt <= SquashCnt + CNTW'(1);
            end
        end
    end

    // Watchdog trips on the edge after MAXSTALL consecutive stalled edges.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            runs     <= '0;
            StallErr <= 1'b0;
        end else begin
            if (!Stall) begin
                runs <= '0;
            end else if (runs != RUN_CAP) begin
                runs <= runs + RUNW'(1);
            end
            if (Stall && runs == RUN_TRIP) begin
                StallErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// tb/tb_pipe_stall_flush_ctrl.sv - directed self-checking bench for pipe_stall_flush_ctrl
module tb_pipe_stall_flush_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn, Stall, Flush, PCSrcD;
    logic [31:0] PCBranchD, InstrF;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD, ValidE, StallErr;
    logic [7:0]  CtrlD, CtrlE;
    logic [31:0] RFRD1D, RFRD2D, SImmD, RFRD1E, RFRD2E, SImmE;
    logic [4:0]  rsD, rtD, rtdD, rsE, rtE, rtdE;
    logic [15:0] StallCnt, SquashCnt;

    logic [31:0] n_PCF, n_InstrD, n_PCPlus4D, n_RFRD1E, n_RFRD2E, n_SImmE;
    logic        n_ValidD, n_ValidE, n_StallErr;
    logic [7:0]  n_CtrlE;
    logic [4:0]  n_rsE, n_rtE, n_rtdE;
    logic [3:0]  n_StallCnt, n_SquashCnt;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_stall_flush_ctrl dut (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .Flush(Flush), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .CtrlD(CtrlD), .RFRD1D(RFRD1D),
        .RFRD2D(RFRD2D), .SImmD(SImmD), .rsD(rsD), .rtD(rtD), .rtdD(rtdD),
        .CtrlE(CtrlE), .RFRD1E(RFRD1E), .RFRD2E(RFRD2E), .SImmE(SImmE),
        .rsE(rsE), .rtE(rtE), .rtdE(rtdE), .ValidE(ValidE),
        .StallCnt(StallCnt), .SquashCnt(SquashCnt), .StallErr(StallErr)
    );

    pipe_stall_flush_ctrl #(.CNTW(4)) dut_narrow (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .Flush(Flush), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .InstrF(InstrF), .PCF(n_PCF), .InstrD(n_InstrD),
        .PCPlus4D(n_PCPlus4D), .ValidD(n_ValidD), .CtrlD(CtrlD), .RFRD1D(RFRD1D),
        .RFRD2D(RFRD2D), .SImmD(SImmD), .rsD(rsD), .rtD(rtD), .rtdD(rtdD),
        .CtrlE(n_CtrlE), .RFRD1E(n_RFRD1E), .RFRD2E(n_RFRD2E), .SImmE(n_SImmE),
        .rsE(n_rsE), .rtE(n_rtE), .rtdE(n_rtdE), .ValidE(n_ValidE),
        .StallCnt(n_StallCnt), .SquashCnt(n_SquashCnt), .StallErr(n_StallErr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTn = 1'b0; Stall = 1'b0; Flush = 1'b0; PCSrcD = 1'b0;
        PCBranchD = '0; InstrF = 32'h2008_0005;
        CtrlD = 8'hA5; RFRD1D = 32'h1111_1111; RFRD2D = 32'h2222_2222; SImmD = 32'h5;
        rsD = 5'd1; rtD = 5'd2; rtdD = 5'd8;

        step();
        check("rst_pcf", PCF, 32'h0);
        check("rst_validd", {31'b0, ValidD}, 32'h0);
        check("rst_valide", {31'b0, ValidE}, 32'h0);
        check("rst_stallcnt", {16'b0, StallCnt}, 32'h0);
        check("rst_stallerr", {31'b0, StallErr}, 32'h0);
        RSTn = 1'b1;

        step();
        check("e1_pcf", PCF, 32'h4);
        check("e1_instrd", InstrD, 32'h2008_0005);
        check("e1_pcplus4d", PCPlus4D, 32'h4);
        check("e1_validd", {31'b0, ValidD}, 32'h1);
        check("e1_valide", {31'b0, ValidE}, 32'h0);
        step();
        check("e2_pcf", PCF, 32'h8);
        check("e2_valide", {31'b0, ValidE}, 32'h1);
        check("e2_ctrle", {24'b0, CtrlE}, 32'hA5);
        check("e2_rtde", {27'b0, rtdE}, 32'h8);
        check("e2_rfrd1e", RFRD1E, 32'h1111_1111);
        step();
        check("e3_pcf", PCF, 32'hC);
        step();
        check("e4_pcf", PCF, 32'h10);

        Stall = 1'b1; Flush = 1'b1;
        step();
        check("sf_pcf", PCF, 32'h10);
        check("sf_instrd", InstrD, 32'h2008_0005);
        check("sf_pcplus4d", PCPlus4D, 32'h10);
        check("sf_ctrle", {24'b0, CtrlE}, 32'h0);
        check("sf_valide", {31'b0, ValidE}, 32'h0);
        check("sf_rtde", {27'b0, rtdE}, 32'h0);
        check("sf_rfrd1e", RFRD1E, 32'h0);
        check("sf_stallcnt", {16'b0, StallCnt}, 32'h1);
        Stall = 1'b0; Flush = 1'b0;
        step();
        check("post_sf_pcf", PCF, 32'h14);
        check("post_sf_valide", {31'b0, ValidE}, 32'h1);

        PCSrcD = 1'b1; PCBranchD = 32'h40;
        step();
        check("br_pcf", PCF, 32'h40);
        check("br_instrd", InstrD, 32'h0);
        check("br_pcplus4d", PCPlus4D, 32'h0);
        check("br_validd", {31'b0, ValidD}, 32'h0);
        check("br_squashcnt", {16'b0, SquashCnt}, 32'h1);

        Stall = 1'b1;
        step();
        check("stbr_pcf", PCF, 32'h40);
        check("stbr_squashcnt", {16'b0, SquashCnt}, 32'h1);
        check("stbr_stallcnt", {16'b0, StallCnt}, 32'h2);
        check("stbr_valide", {31'b0, ValidE}, 32'h0);
        Stall = 1'b0; PCSrcD = 1'b0;
        step();
        check("resume_pcf", PCF, 32'h44);
        check("resume_validd", {31'b0, ValidD}, 32'h1);

        Stall = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("wd_err_%0d", i), {31'b0, StallErr}, (i == 9) ? 32'h1 : 32'h0);
        end
        check("wd_pcf_held", PCF, 32'h44);
        check("wd_stallcnt", {16'b0, StallCnt}, 32'd11);
        Stall = 1'b0;
        step();
        check("wd_sticky", {31'b0, StallErr}, 32'h1);
        check("wd_release_pcf", PCF, 32'h48);

        PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
        step();
        check("wrap_pre_pcf", PCF, 32'hFFFF_FFFC);
        check("wrap_squashcnt", {16'b0, SquashCnt}, 32'h2);
        PCSrcD = 1'b0;
        step();
        check("wrap_pcf", PCF, 32'h0);
        check("wrap_pcplus4d", PCPlus4D, 32'h0);

        Stall = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("sat_narrow", {28'b0, n_StallCnt}, 32'hF);
        check("sat_wide", {16'b0, StallCnt}, 32'd17);

        #2;
        RSTn = 1'b0;
        #1;
        check("arst_pcf", PCF, 32'h0);
        check("arst_instrd", InstrD, 32'h0);
        check("arst_pcplus4d", PCPlus4D, 32'h0);
        check("arst_stallcnt", {16'b0, StallCnt}, 32'h0);
        check("arst_squashcnt", {16'b0, SquashCnt}, 32'h0);
        check("arst_stallerr", {31'b0, StallErr}, 32'h0);
        check("arst_ctrle", {24'b0, CtrlE}, 32'h0);
        check("arst_narrow_cnt", {28'b0, n_StallCnt}, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < 8; i++) step();
        check("post_rst_err", {31'b0, StallErr}, 32'h0);
        check("post_rst_stallcnt", {16'b0, StallCnt}, 32'd8);
        check("post_rst_pcf", PCF, 32'h0);
        Stall = 1'b0;
        step();
        check("post_rst_run_pcf", PCF, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_flush_ctrl.md
Name: pipe_stall_flush_ctrl

Overview:
- Acts on the stall, flush and branch-redirect decisions from the hazard detection logic: it owns the PC register, the IF/ID pipeline register and the ID/EX pipeline register of the 5-stage pipeline.
- Freezes PC and IF/ID on stall, inserts an ID/EX bubble on flush, and squashes IF/ID on a taken branch resolved in ID.
- Keeps saturating stall/squash counters and a stall watchdog for debug.

Parameters:
- WL, 32, datapath/PC width.
- WLinput, 5, register-address width.
- CTRLW, 8, ID/EX control bundle width; bit0 = RFWE, bit1 = MtoRFSel, bit2 = DMWE, bit3 = Branch, bits 7:4 = ALUSel.
- CNTW, 16, performance counter width.
- MAXSTALL, 8, consecutive stall cycles tolerated before the watchdog fires.

Ports:
- CLK  in  1  single clock.
- RSTn  in  1  asynchronous, active-low reset.
- Stall  in  1  freeze PC and IF/ID.
- Flush  in  1  bubble into ID/EX.
- PCSrcD  in  1  taken branch resolved in ID.
- PCBranchD  in  WL  branch target.
- InstrF  in  WL  fetched instruction.
- PCF  out  WL  current fetch PC.
- InstrD  out  WL  IF/ID instruction.
- PCPlus4D  out  WL  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- CtrlD  in  CTRLW  decoded control.
- RFRD1D, RFRD2D, SImmD  in  WL each  operands/immediate.
- rsD, rtD, rtdD  in  WLinput each  register addresses.
- CtrlE  out  CTRLW  registered control.
- RFRD1E, RFRD2E, SImmE  out  WL each  registered operands/immediate.
- rsE, rtE, rtdE  out  WLinput each  registered register addresses.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCnt  out  CNTW  total stall cycles.
- SquashCnt  out  CNTW  total taken-branch squashes.
- StallErr  out  1  sticky watchdog flag.

Behaviour:
- Reset (RSTn=0, async): every output register is 0, including PCF, InstrD, PCPlus4D, ValidD, all E outputs, counters and StallErr. The internal consecutive-stall counter runs is 0.
- Reset may assert mid-operation; any in-flight state is discarded.
- First rising CLK after RSTn deasserts is a normal update.
- All updates occur on the rising CLK edge. Each register stage has 1-cycle latency.

PC register, priority Stall > PCSrcD > sequential:
- Stall=1: hold.
- Else PCSrcD=1: PCF <= PCBranchD.
- Else: PCF <= PCF+4, modulo 2^WL, so 0xFFFFFFFC wraps to 0.

IF/ID register:
- Stall=1: hold all fields. Squash is ignored because a stalled branch is not yet resolved.
- Else PCSrcD=1: InstrD <= 0 (nop), PCPlus4D <= 0, ValidD <= 0, SquashCnt++.
- Else: InstrD <= InstrF, PCPlus4D <= PCF+4, ValidD <= 1.

ID/EX register:
- Flush=1: CtrlE <= 0, rsE/rtE/rtdE <= 0, ValidE <= 0. Data fields RFRD1E/RFRD2E/SImmE <= 0.
- Else: load all D inputs; ValidE <= ValidD.
- Flush and Stall are normally asserted together. The combination is legal and yields a held IF/ID plus a bubble in E.
- Stall without Flush holds IF/ID while ID/EX still loads, duplicating the instruction. This is legal and not checked.

Counters:
- StallCnt increments on each edge with Stall=1 and saturates at 2^CNTW-1.
- SquashCnt increments on each IF/ID squash and saturates likewise.

Watchdog:
- runs increments while Stall=1 and clears to 0 when Stall=0; it saturates at MAXSTALL+1.
- StallErr <= 1 when runs reaches MAXSTALL and Stall is still 1. It is sticky until reset.
- The pipeline keeps honouring Stall after StallErr sets.

Inputs must be 0/1 on every edge; X on Stall/Flush/PCSrcD is a bench error.

Test Plan:
- Reset then 4 free cycles, InstrF=0x20080005 -> PCF sequence 0,4,8,12,16; after the 2nd edge InstrD=0x20080005, PCPlus4D=4, ValidD=1; ValidE=1 from the 3rd edge.
- Stall=1 and Flush=1 for 1 cycle with PCF=0x10 -> PCF stays 0x10, IF/ID unchanged, CtrlE=0, ValidE=0, rtdE=0, StallCnt=1; next free cycle PCF=0x14.
- PCSrcD=1, PCBranchD=0x40, Stall=0 -> next edge PCF=0x40, InstrD=0, ValidD=0, SquashCnt=1. Repeat with Stall=1 and PCSrcD=1 -> PCF held, no squash, SquashCnt unchanged.
- Stall held 8 cycles (MAXSTALL=8) -> StallErr=0 through the 8th edge, StallErr=1 on the 9th. Release Stall -> StallErr stays 1 until RSTn pulse.
- PCF=0xFFFFFFFC, no stall/branch -> PCF=0x00000000 next edge. StallCnt preloaded near max (CNTW=4, 16 stall cycles) -> holds 0xF.
- Assert RSTn=0 mid-stall between clock edges -> all outputs 0 immediately without a CLK edge; StallErr cleared.
